// File: rtl/tlul_txn_limiter_if.sv
// ============================================================================
// Module   : tlul_txn_limiter_if
// Brief    : TL-UL A/D channel bundle with host (master) and device (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlul_txn_limiter_if #(
  parameter int SRC_W = 8
) ();
  logic             a_valid;
  logic [2:0]       a_opcode;
  logic [1:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;
  logic             a_ready;

  logic             d_valid;
  logic [2:0]       d_opcode;
  logic [1:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic [31:0]      d_data;
  logic             d_error;
  logic             d_ready;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
  );
endinterface

`default_nettype wire

// File: rtl/tlul_txn_limiter.sv
// ============================================================================
// Module   : tlul_txn_limiter
// Brief    : Caps in-flight TL-UL requests, offers a drain handshake and flags
//            out-of-order or unsolicited D responses with a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_txn_limiter #(
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int SRC_W           = 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  tlul_txn_limiter_if.slave   tl_h,
  tlul_txn_limiter_if.master  tl_d,
  input  wire logic           drain_req_i,
  output logic                drained_o,
  output logic                idle_o,
  output logic [CNT_W-1:0]    outstanding_o,
  output logic                err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] C_MAX_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_drained;
  logic             r_a_pend;
  logic             r_err;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [SRC_W-1:0] r_src_q [MAX_OUTSTANDING];

  logic w_blk;
  logic w_a_hs;
  logic w_d_hs;
  logic w_underflow;
  logic w_pop;
  logic w_mismatch;

  // Blocking uses registers only, so D activity can never reach a_valid combinationally.
  assign w_blk = ~r_a_pend & ((r_count == C_MAX_CNT) | (r_state != ST_ACTIVE));

  assign tl_d.a_valid   = tl_h.a_valid & ~w_blk;
  assign tl_h.a_ready   = tl_d.a_ready & ~w_blk;
  assign tl_d.a_opcode  = tl_h.a_opcode;
  assign tl_d.a_size    = tl_h.a_size;
  assign tl_d.a_source  = tl_h.a_source;
  assign tl_d.a_address = tl_h.a_address;
  assign tl_d.a_mask    = tl_h.a_mask;
  assign tl_d.a_data    = tl_h.a_data;

  assign tl_h.d_valid   = tl_d.d_valid;
  assign tl_h.d_opcode  = tl_d.d_opcode;
  assign tl_h.d_size    = tl_d.d_size;
  assign tl_h.d_source  = tl_d.d_source;
  assign tl_h.d_data    = tl_d.d_data;
  assign tl_h.d_error   = tl_d.d_error;
  assign tl_d.d_ready   = tl_h.d_ready;

  assign w_a_hs      = tl_d.a_valid & tl_d.a_ready;
  assign w_d_hs      = tl_h.d_valid & tl_h.d_ready;
  assign w_underflow = w_d_hs & (r_count == '0);
  assign w_pop       = w_d_hs & ~w_underflow;
  assign w_mismatch  = w_pop & (tl_d.d_source != r_src_q[r_rd_ptr]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_a_pend <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case ({w_a_hs, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_a_hs) begin
        r_wr_ptr <= (r_wr_ptr == C_MAX_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_MAX_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_a_hs) begin
        r_a_pend <= 1'b0;
      end else if (tl_d.a_valid & ~tl_d.a_ready) begin
        r_a_pend <= 1'b1;
      end
      if (w_underflow | w_mismatch) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_a_hs) begin
      r_src_q[r_wr_ptr] <= tl_d.a_source;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_ACTIVE;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (drain_req_i) begin
            r_state <= ST_DRAINING;
          end
          r_drained <= 1'b0;
        end
        ST_DRAINING: begin
          if (!drain_req_i) begin
            r_state   <= ST_ACTIVE;
            r_drained <= 1'b0;
          end else if ((r_count == '0) && !r_a_pend) begin
            r_state   <= ST_DRAINED;
            r_drained <= 1'b1;
          end else begin
            r_drained <= 1'b0;
          end
        end
        ST_DRAINED: begin
          if (!drain_req_i) begin
            r_state   <= ST_ACTIVE;
            r_drained <= 1'b0;
          end else begin
            r_drained <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_ACTIVE;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

  assign drained_o     = r_drained;
  assign idle_o        = (r_count == '0);
  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tlul_txn_limiter.sv
// ============================================================================
// Module   : tb_tlul_txn_limiter
// Brief    : Scenario and randomized checks of tlul_txn_limiter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlul_txn_limiter;

  localparam int C_MAX = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       drain_req_i;
  logic       drained_o;
  logic       idle_o;
  logic [2:0] outstanding_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  tlul_txn_limiter_if #(.SRC_W(8)) h_if ();
  tlul_txn_limiter_if #(.SRC_W(8)) d_if ();

  tlul_txn_limiter #(.MAX_OUTSTANDING(C_MAX), .SRC_W(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tl_h          (h_if),
    .tl_d          (d_if),
    .drain_req_i   (drain_req_i),
    .drained_o     (drained_o),
    .idle_o        (idle_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    h_if.a_valid   = 1'b0;
    h_if.a_opcode  = 3'd4;
    h_if.a_size    = 2'd2;
    h_if.a_source  = 8'd0;
    h_if.a_address = 32'h0;
    h_if.a_mask    = 4'hf;
    h_if.a_data    = 32'h0;
    h_if.d_ready   = 1'b1;
    d_if.a_ready   = 1'b1;
    d_if.d_valid   = 1'b0;
    d_if.d_opcode  = 3'd1;
    d_if.d_size    = 2'd2;
    d_if.d_source  = 8'd0;
    d_if.d_data    = 32'h0;
    d_if.d_error   = 1'b0;
    drain_req_i    = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [7:0] src);
    h_if.a_valid  = 1'b1;
    h_if.a_source = src;
    tick();
    h_if.a_valid  = 1'b0;
  endtask

  task automatic respond(input logic [7:0] src);
    d_if.d_valid  = 1'b1;
    d_if.d_source = src;
    tick();
    d_if.d_valid  = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_i = 1'b1;
    #3;
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", outstanding_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle_o); end
    checks++; if (drained_o !== 1'b0) begin errors++; $display("FAIL reset_drained got=%b exp=0", drained_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_full_block();
    for (int i = 0; i < C_MAX; i++) begin
      h_if.a_valid  = 1'b1;
      h_if.a_source = 8'(i);
      settle();
      checks++; if (d_if.a_valid !== 1'b1) begin errors++; $display("FAIL fill_a_valid[%0d] got=%b exp=1", i, d_if.a_valid); end
      tick();
    end
    h_if.a_source = 8'd4;
    settle();
    checks++; if (d_if.a_valid !== 1'b0) begin errors++; $display("FAIL full_a_valid got=%b exp=0", d_if.a_valid); end
    checks++; if (h_if.a_ready !== 1'b0) begin errors++; $display("FAIL full_a_ready got=%b exp=0", h_if.a_ready); end
    checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", outstanding_o); end
    d_if.d_valid  = 1'b1;
    d_if.d_source = 8'd0;
    settle();
    checks++; if (d_if.a_valid !== 1'b0) begin errors++; $display("FAIL full_cycle_gate got=%b exp=0", d_if.a_valid); end
    tick();
    d_if.d_valid = 1'b0;
    settle();
    checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL after_dhs_count got=%0d exp=3", outstanding_o); end
    checks++; if (d_if.a_valid !== 1'b1) begin errors++; $display("FAIL fifth_issues got=%b exp=1", d_if.a_valid); end
    tick();
    h_if.a_valid = 1'b0;
    checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL refill_count got=%0d exp=4", outstanding_o); end
    for (int i = 1; i <= 4; i++) respond(8'(i));
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL in_order_err got=%b exp=0", err_o); end
  endtask

  task automatic test_back_to_back();
    issue(8'd10);
    issue(8'd11);
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL b2b_pre got=%0d exp=2", outstanding_o); end
    h_if.a_valid  = 1'b1;
    h_if.a_source = 8'd12;
    d_if.d_valid  = 1'b1;
    d_if.d_source = 8'd10;
    tick();
    h_if.a_valid = 1'b0;
    d_if.d_valid = 1'b0;
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", outstanding_o); end
    respond(8'd11);
    respond(8'd12);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b exp=0", err_o); end
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL b2b_final got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_mismatch();
    do_reset();
    issue(8'd3);
    issue(8'd5);
    respond(8'd5);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mismatch_err got=%b exp=1", err_o); end
    checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL mismatch_count got=%0d exp=1", outstanding_o); end
    respond(8'd3);
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mismatch_sticky got=%b exp=1", err_o); end
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL mismatch_final got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_underflow();
    do_reset();
    respond(8'd9);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL underflow_err got=%b exp=1", err_o); end
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_stall_drain();
    do_reset();
    d_if.a_ready  = 1'b0;
    h_if.a_valid  = 1'b1;
    h_if.a_source = 8'd7;
    tick();
    drain_req_i = 1'b1;
    tick();
    checks++; if (d_if.a_valid !== 1'b1) begin errors++; $display("FAIL stall_hold1 got=%b exp=1", d_if.a_valid); end
    tick();
    checks++; if (d_if.a_valid !== 1'b1) begin errors++; $display("FAIL stall_hold2 got=%b exp=1", d_if.a_valid); end
    d_if.a_ready = 1'b1;
    tick();
    h_if.a_source = 8'd8;
    settle();
    checks++; if (d_if.a_valid !== 1'b0) begin errors++; $display("FAIL drain_block got=%b exp=0", d_if.a_valid); end
    checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL drain_count got=%0d exp=1", outstanding_o); end
    checks++; if (drained_o !== 1'b0) begin errors++; $display("FAIL drain_early got=%b exp=0", drained_o); end
    respond(8'd7);
    checks++; if (drained_o !== 1'b0) begin errors++; $display("FAIL drained_same got=%b exp=0", drained_o); end
    tick();
    checks++; if (drained_o !== 1'b1) begin errors++; $display("FAIL drained_set got=%b exp=1", drained_o); end
    checks++; if (d_if.a_valid !== 1'b0) begin errors++; $display("FAIL drained_block got=%b exp=0", d_if.a_valid); end
    drain_req_i = 1'b0;
    tick();
    checks++; if (drained_o !== 1'b0) begin errors++; $display("FAIL resume_drained got=%b exp=0", drained_o); end
    checks++; if (d_if.a_valid !== 1'b1) begin errors++; $display("FAIL resume_a_valid got=%b exp=1", d_if.a_valid); end
    tick();
    h_if.a_valid = 1'b0;
    respond(8'd8);
    checks++; if (err_o !== 1'b0 || outstanding_o !== 3'd0) begin
      errors++; $display("FAIL drain_final err=%b count=%0d exp err=0 count=0", err_o, outstanding_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(8'd1);
    issue(8'd2);
    issue(8'd3);
    checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL mid_pre got=%0d exp=3", outstanding_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", outstanding_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL mid_idle got=%b exp=1", idle_o); end
    checks++; if (err_o !== 1'b0 || drained_o !== 1'b0) begin
      errors++; $display("FAIL mid_flags err=%b drained=%b exp 0/0", err_o, drained_o);
    end
    rst_i = 1'b0;
    tick();
    issue(8'd20);
    respond(8'd20);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_queue_clear got=%b exp=0", err_o); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    bit         pend;
    bit         hv, ar, dv, dr, exp_av, exp_ar, a_hs, d_hs;
    logic [7:0] src;
    logic [31:0] addr;
    do_reset();
    pend = 1'b0;
    src  = 8'd0;
    addr = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend) begin
        hv   = ($urandom_range(0, 99) < 60);
        src  = 8'($urandom);
        addr = $urandom;
      end
      ar = ($urandom_range(0, 99) < 60);
      dv = (q.size() > 0) && ($urandom_range(0, 99) < 45);
      dr = ($urandom_range(0, 99) < 70);
      h_if.a_valid   = hv;
      h_if.a_source  = src;
      h_if.a_address = addr;
      h_if.d_ready   = dr;
      d_if.a_ready   = ar;
      d_if.d_valid   = dv;
      d_if.d_source  = dv ? q[0] : 8'($urandom);
      d_if.d_data    = $urandom;
      settle();
      exp_av = hv && (pend || q.size() < C_MAX);
      exp_ar = ar && (pend || q.size() < C_MAX);
      checks++; if (d_if.a_valid !== exp_av || h_if.a_ready !== exp_ar) begin
        errors++; $display("FAIL rnd_gate cyc=%0d a_valid=%b a_ready=%b exp %b %b", cyc, d_if.a_valid, h_if.a_ready, exp_av, exp_ar);
      end
      checks++; if (d_if.a_address !== addr || d_if.a_source !== src || h_if.d_data !== d_if.d_data
                    || h_if.d_valid !== dv || d_if.d_ready !== dr) begin
        errors++; $display("FAIL rnd_passthru cyc=%0d addr=%h src=%h exp addr=%h src=%h", cyc, d_if.a_address, d_if.a_source, addr, src);
      end
      a_hs = exp_av && ar;
      d_hs = dv && dr;
      tick();
      if (d_hs) void'(q.pop_front());
      if (a_hs) q.push_back(src);
      pend = exp_av && !ar;
      checks++; if (outstanding_o !== 3'(q.size()) || idle_o !== (q.size() == 0) || err_o !== 1'b0) begin
        errors++; $display("FAIL rnd_status cyc=%0d count=%0d idle=%b err=%b exp count=%0d", cyc, outstanding_o, idle_o, err_o, q.size());
      end
    end
    quiet_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    quiet_inputs();
    test_reset();
    test_full_block();
    test_back_to_back();
    test_mismatch();
    test_underflow();
    test_stall_drain();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
